dg_sram_arb: RTL

//  Shares one command SRAM between N_PORT per-port data-gen fetch controllers.

---
 rtl/dg_sram_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dg_sram_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dg_sram_arb : round-robin read arbiter sharing one command SRAM between ports
// Revision    : 1.0
// ----------------------------------------------------------------------------
module dg_sram_arb #(
  parameter int N_PORT = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_PORT-1:0]                i_rden,
  input  logic [N_PORT*ADDR_W-1:0]         i_addr,
  output logic [N_PORT-1:0]                o_busy,
  output logic [DATA_W-1:0]                o_rdata,
  output logic [N_PORT-1:0]                o_rvld,
  output logic [N_PORT-1:0]                o_ovf,
  output logic                             o_sram_rden,
  output logic [$clog2(N_PORT)+ADDR_W-1:0] o_sram_addr,
  input  logic [DATA_W-1:0]                i_sram_data
);
  localparam int PORT_W = $clog2(N_PORT);
  localparam int SA_W   = PORT_W + ADDR_W;
  localparam logic [PORT_W-1:0] PORT_ONE = PORT_W'(1);

  logic [N_PORT-1:0]             pend_q, pend_d;
  logic [N_PORT-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [N_PORT-1:0]             ovf_q, ovf_d;
  logic [PORT_W-1:0]             ptr_q, ptr_d;
  logic                          sram_rden_q, sram_rden_d;
  logic [SA_W-1:0]               sram_addr_q, sram_addr_d;
  logic [RD_LAT-1:0][PORT_W:0]   tag_q, tag_d;
  logic [DATA_W-1:0]             rdata_q, rdata_d;
  logic [N_PORT-1:0]             rvld_q, rvld_d;
  logic                          gnt_vld;
  logic [PORT_W-1:0]             gnt_idx, srch_idx;

  // Round-robin search: the index wraps for free because N_PORT is a power of two.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    srch_idx = '0;
    for (int i = 0; i < N_PORT; i++) begin
      srch_idx = ptr_q + PORT_W'(i);
      if (!gnt_vld && pend_q[srch_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = srch_idx;
      end
    end
  end

  always_comb begin
    pend_d      = pend_q;
    addr_d      = addr_q;
    ovf_d       = ovf_q;
    ptr_d       = ptr_q;
    sram_rden_d = gnt_vld;
    sram_addr_d = sram_addr_q;
    tag_d       = tag_q;
    rdata_d     = rdata_q;
    rvld_d      = '0;

    // A request arriving on the edge its port is granted re-arms the port.
    for (int p = 0; p < N_PORT; p++) begin
      if (gnt_vld && (gnt_idx == PORT_W'(p))) begin
        pend_d[p] = 1'b0;
        if (i_rden[p]) begin
          pend_d[p] = 1'b1;
          addr_d[p] = i_addr[p*ADDR_W +: ADDR_W];
        end
      end else if (i_rden[p]) begin
        if (pend_q[p]) begin
          ovf_d[p] = 1'b1;
        end else begin
          pend_d[p] = 1'b1;
          addr_d[p] = i_addr[p*ADDR_W +: ADDR_W];
        end
      end
    end

    if (gnt_vld) begin
      sram_addr_d = {gnt_idx, addr_q[gnt_idx]};
      ptr_d       = gnt_idx + PORT_ONE;
    end

    // Tag enters alongside the SRAM strobe and exits when its data is valid.
    tag_d[0] = {sram_rden_q, sram_addr_q[SA_W-1 -: PORT_W]};
    for (int k = 1; k < RD_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    if (tag_q[RD_LAT-1][PORT_W]) begin
      rdata_d = i_sram_data;
      rvld_d[tag_q[RD_LAT-1][PORT_W-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      addr_q      <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      sram_rden_q <= 1'b0;
      sram_addr_q <= '0;
      tag_q       <= '0;
      rdata_q     <= '0;
      rvld_q      <= '0;
    end else begin
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      sram_rden_q <= sram_rden_d;
      sram_addr_q <= sram_addr_d;
      tag_q       <= tag_d;
      rdata_q     <= rdata_d;
      rvld_q      <= rvld_d;
    end
  end

  assign o_busy      = pend_q;
  assign o_ovf       = ovf_q;
  assign o_sram_rden = sram_rden_q;
  assign o_sram_addr = sram_addr_q;
  assign o_rdata     = rdata_q;
  assign o_rvld      = rvld_q;

endmodule
`default_nettype wire
